// File: rtl/vregfile_stream.sv
// Vector register file: NREGS x LANES elements, two masked combinational read ports,
// a vl-masked parallel write port and a lane-serial streaming fill port.
module vregfile_stream #(
    parameter int NREGS = 16,
    parameter int LANES = 5,
    parameter int XLEN  = 32,
    localparam int RW   = $clog2(NREGS),
    localparam int VLW  = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VLW-1:0]        vl,
    input  logic [RW-1:0]         ra1,
    input  logic [RW-1:0]         ra2,
    output logic [LANES*XLEN-1:0] rd1,
    output logic [LANES*XLEN-1:0] rd2,
    input  logic                  we,
    input  logic [RW-1:0]         wa,
    input  logic [LANES*XLEN-1:0] wd,
    input  logic                  st_start,
    input  logic [RW-1:0]         st_reg,
    input  logic                  st_valid,
    input  logic [XLEN-1:0]       st_data,
    output logic                  st_ready,
    output logic                  st_busy,
    output logic                  st_done,
    output logic                  wr_conflict
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [VLW-1:0] LANES_V = VLW'(LANES);

    logic [XLEN-1:0] r_rf [NREGS][LANES];
    logic [1:0]      r_state;
    logic [RW-1:0]   r_tgt;
    logic [VLW-1:0]  r_len;
    logic [VLW-1:0]  r_cnt;
    logic            r_conflict;

    logic [VLW-1:0]  w_vl_eff;
    logic            w_streaming;
    logic            w_st_wr;
    logic            w_drop;
    logic            w_par_wr;

    assign w_vl_eff    = (vl > LANES_V) ? LANES_V : vl;
    assign w_streaming = (r_state == S_STREAM);
    assign w_st_wr     = w_streaming && st_valid;
    // A parallel write aimed at the register being filled loses to the stream.
    assign w_drop      = w_streaming && we && (wa == r_tgt);
    assign w_par_wr    = we && !w_drop;

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < LANES; i++) begin
            if (VLW'(i) < w_vl_eff) begin
                rd1[i*XLEN +: XLEN] = r_rf[ra1][i];
                rd2[i*XLEN +: XLEN] = r_rf[ra2][i];
            end
        end
    end

    // NOTE: every element is cleared by reset, so this storage must stay in flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_rf[r][l] <= '0;
                end
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (w_par_wr && (VLW'(l) < w_vl_eff)) begin
                    r_rf[wa][l] <= wd[l*XLEN +: XLEN];
                end
            end
            if (w_st_wr) begin
                r_rf[r_tgt][r_cnt] <= st_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tgt      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_drop;
            case (r_state)
                S_IDLE: begin
                    if (st_start) begin
                        if (w_vl_eff != '0) begin
                            r_tgt   <= st_reg;
                            r_len   <= w_vl_eff;
                            r_cnt   <= '0;
                            r_state <= S_STREAM;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_STREAM: begin
                    if (st_valid) begin
                        r_cnt <= r_cnt + VLW'(1);
                        if (r_cnt == r_len - VLW'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign st_ready    = (r_state == S_STREAM);
    assign st_busy     = (r_state != S_IDLE);
    assign st_done     = (r_state == S_DONE);
    assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_vregfile_stream.sv
// Self-checking bench for vregfile_stream: directed scenarios plus randomized
// writes and streams compared against an array model of the register file.
module tb_vregfile_stream;

    localparam int NREGS = 16;
    localparam int LANES = 5;
    localparam int XLEN  = 32;
    localparam int RW    = 4;
    localparam int VLW   = 3;
    localparam int VW    = LANES * XLEN;

    logic           clk = 1'b0;
    logic           reset;
    logic [VLW-1:0] vl;
    logic [RW-1:0]  ra1, ra2, wa, st_reg;
    logic [VW-1:0]  rd1, rd2, wd;
    logic           we, st_start, st_valid;
    logic           st_ready, st_busy, st_done, wr_conflict;
    logic [XLEN-1:0] st_data;

    int n_pass   = 0;
    int n_checks = 0;

    logic [XLEN-1:0] mdl [NREGS][LANES];

    vregfile_stream #(.NREGS(NREGS), .LANES(LANES), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .vl(vl),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd),
        .st_start(st_start), .st_reg(st_reg), .st_valid(st_valid), .st_data(st_data),
        .st_ready(st_ready), .st_busy(st_busy), .st_done(st_done),
        .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input int v);
        return (v > LANES) ? LANES : v;
    endfunction

    function automatic logic [VW-1:0] exp_rd(input int r, input int v);
        logic [VW-1:0] x = '0;
        for (int i = 0; i < eff(v); i++) x[i*XLEN +: XLEN] = mdl[r][i];
        return x;
    endfunction

    function automatic logic [VW-1:0] pack5(input logic [XLEN-1:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] x;
        for (int i = 0; i < LANES; i++) x[i*XLEN +: XLEN] = $urandom;
        return x;
    endfunction

    function automatic void mdl_clear();
        for (int r = 0; r < NREGS; r++)
            for (int l = 0; l < LANES; l++) mdl[r][l] = '0;
    endfunction

    task automatic par_write(input int r, input logic [VW-1:0] d, input int v);
        we = 1'b1; wa = RW'(r); wd = d; vl = VLW'(v);
        tick();
        we = 1'b0;
        for (int i = 0; i < eff(v); i++) mdl[r][i] = d[i*XLEN +: XLEN];
    endtask

    // Drives one complete stream and tracks expected handshake behaviour from
    // the element count alone. mode 1: two stall cycles after the 2nd element,
    // data = 3,4,5,...; mode 0: random stalls with stall_pct percent, random data.
    task automatic run_stream(input int r, input int v, input int mode, input int stall_pct,
                              output int ready_seen, output int ready_exp,
                              output int done_seen, output int seq_err);
        int len, acc, stalls;
        bit in_stream, done_now, finished;
        logic vld;
        logic [XLEN-1:0] dat;
        len = eff(v); acc = 0; stalls = 0;
        ready_seen = 0; ready_exp = 0; done_seen = 0; seq_err = 0;
        st_start = 1'b1; st_reg = RW'(r); vl = VLW'(v);
        tick();
        st_start  = 1'b0;
        in_stream = (len > 0);
        done_now  = (len == 0);
        finished  = 1'b0;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            if (!in_stream) vld = 1'b0;
            else if (mode == 1) begin
                vld = !(acc == 2 && stalls < 2);
                if (!vld) stalls++;
            end else vld = ($urandom_range(99) >= stall_pct);
            dat = (mode == 1) ? XLEN'(acc + 3) : $urandom;
            st_valid = vld; st_data = dat;
            #1;
            if (st_ready !== in_stream || st_done !== done_now || st_busy !== 1'b1) seq_err++;
            if (st_ready === 1'b1) ready_seen++;
            if (st_done === 1'b1) done_seen++;
            ready_exp += int'(in_stream);
            if (done_now) finished = 1'b1;
            done_now = 1'b0;
            if (in_stream && vld) begin
                mdl[r][acc] = dat;
                acc++;
                if (acc == len) begin
                    in_stream = 1'b0;
                    done_now  = 1'b1;
                end
            end
            tick();
        end
        st_valid = 1'b0;
        if (!finished) seq_err++;
    endtask

    task automatic test_reset();
        par_write(1, rand_vec(), 5);
        st_start = 1'b1; st_reg = 4; vl = 5;
        tick();
        st_start = 1'b0; st_valid = 1'b1; st_data = $urandom;
        tick();
        st_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int r = 0; r < NREGS; r++) begin
            ra1 = RW'(r); ra2 = RW'(NREGS - 1 - r);
            #1;
            n_checks++;
            if (rd1 !== '0 || rd2 !== '0)
                $display("FAIL reset_read r%0d: rd1=%h rd2=%h required 0", r, rd1, rd2);
            else n_pass++;
        end
        n_checks++;
        if ({st_busy, st_ready, st_done, wr_conflict} !== 4'b0000)
            $display("FAIL reset_status: busy/ready/done/conflict=%b required 0000",
                     {st_busy, st_ready, st_done, wr_conflict});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({st_busy, st_done} !== 2'b00)
            $display("FAIL reset_held: busy/done=%b required 00", {st_busy, st_done});
        else n_pass++;
        reset = 1'b0;
        mdl_clear();
    endtask

    task automatic test_masked_write();
        par_write(1, pack5(1, 2, 3, 4, 5), 3);
        vl = 5; ra1 = 1; ra2 = 1;
        #1;
        n_checks++;
        if (rd1 !== pack5(1, 2, 3, 0, 0) || rd2 !== pack5(1, 2, 3, 0, 0))
            $display("FAIL masked_vl5: rd1=%h rd2=%h required %h", rd1, rd2, pack5(1, 2, 3, 0, 0));
        else n_pass++;
        vl = 2;
        #1;
        n_checks++;
        if (rd1 !== pack5(1, 2, 0, 0, 0))
            $display("FAIL masked_vl2: rd1=%h required %h", rd1, pack5(1, 2, 0, 0, 0));
        else n_pass++;
        we = 1'b1; wa = 1; wd = pack5(9, 9, 9, 9, 9); vl = 5;
        #1;
        n_checks++;
        if (rd1 !== pack5(1, 2, 3, 0, 0))
            $display("FAIL read_during_write: rd1=%h required %h", rd1, pack5(1, 2, 3, 0, 0));
        else n_pass++;
        tick();
        we = 1'b0;
        for (int i = 0; i < LANES; i++) mdl[1][i] = 9;
        n_checks++;
        if (rd1 !== pack5(9, 9, 9, 9, 9))
            $display("FAIL read_after_write: rd1=%h required %h", rd1, pack5(9, 9, 9, 9, 9));
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            int r;
            r = $urandom_range(NREGS - 1);
            par_write(r, rand_vec(), $urandom_range(7));
            ra1 = RW'($urandom_range(NREGS - 1)); ra2 = RW'(r); vl = VLW'($urandom_range(7));
            #1;
            n_checks++;
            if (rd1 !== exp_rd(int'(ra1), int'(vl)) || rd2 !== exp_rd(r, int'(vl)))
                $display("FAIL random_write %0d: rd1=%h rd2=%h required %h %h", k, rd1, rd2,
                         exp_rd(int'(ra1), int'(vl)), exp_rd(r, int'(vl)));
            else n_pass++;
        end
    endtask

    task automatic test_stream_stalls();
        int rs, re, ds, se;
        run_stream(2, 5, 1, 0, rs, re, ds, se);
        n_checks++;
        if (rs !== 7 || ds !== 1 || se !== 0)
            $display("FAIL stream_stalls: ready=%0d done=%0d seq_err=%0d required 7 1 0", rs, ds, se);
        else n_pass++;
        vl = 5; ra1 = 2;
        #1;
        n_checks++;
        if (rd1 !== pack5(3, 4, 5, 6, 7) || st_busy !== 1'b0)
            $display("FAIL stream_data: rd1=%h busy=%b required %h 0", rd1, st_busy, pack5(3, 4, 5, 6, 7));
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [XLEN-1:0] d [LANES];
        logic [VW-1:0]   ff_vec, v3;
        ff_vec = {LANES{32'h0000_00FF}};
        v3     = rand_vec();
        for (int i = 0; i < LANES; i++) d[i] = $urandom;
        ra1 = 2; ra2 = 3;
        st_start = 1'b1; st_reg = 2; vl = 5;
        tick();
        st_start = 1'b0;
        st_valid = 1'b1; st_data = d[0]; we = 1'b1; wa = 2; wd = ff_vec;
        #1;
        n_checks++;
        if (wr_conflict !== 1'b0) $display("FAIL conflict_early: got %b required 0", wr_conflict);
        else n_pass++;
        tick();
        mdl[2][0] = d[0];
        st_data = d[1]; wa = 3; wd = v3;
        #1;
        n_checks++;
        if (wr_conflict !== 1'b1) $display("FAIL conflict_pulse: got %b required 1", wr_conflict);
        else n_pass++;
        tick();
        mdl[2][1] = d[1];
        for (int i = 0; i < LANES; i++) mdl[3][i] = v3[i*XLEN +: XLEN];
        we = 1'b0; st_data = d[2]; st_start = 1'b1; st_reg = 7;
        #1;
        n_checks++;
        if (wr_conflict !== 1'b0 || st_ready !== 1'b1)
            $display("FAIL conflict_one_cycle: conflict=%b ready=%b required 0 1", wr_conflict, st_ready);
        else n_pass++;
        tick();
        mdl[2][2] = d[2];
        st_start = 1'b0; st_data = d[3]; vl = 1;
        tick();
        mdl[2][3] = d[3];
        st_data = d[4]; vl = 5;
        tick();
        mdl[2][4] = d[4];
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (st_done !== 1'b1 || st_ready !== 1'b0)
            $display("FAIL collision_done: done=%b ready=%b required 1 0", st_done, st_ready);
        else n_pass++;
        n_checks++;
        if (rd1 !== pack5(d[0], d[1], d[2], d[3], d[4]) || rd2 !== exp_rd(3, 5))
            $display("FAIL collision_data: rd1=%h rd2=%h required %h %h", rd1, rd2,
                     pack5(d[0], d[1], d[2], d[3], d[4]), exp_rd(3, 5));
        else n_pass++;
        we = 1'b1; wa = 2; wd = ff_vec;
        tick();
        we = 1'b0;
        for (int i = 0; i < LANES; i++) mdl[2][i] = 32'hFF;
        ra2 = 7;
        #1;
        n_checks++;
        if (wr_conflict !== 1'b0 || st_busy !== 1'b0 || rd1 !== ff_vec || rd2 !== exp_rd(7, 5))
            $display("FAIL done_write: conflict=%b busy=%b rd1=%h rd2=%h required 0 0 %h %h",
                     wr_conflict, st_busy, rd1, rd2, ff_vec, exp_rd(7, 5));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        st_start = 1'b1; st_reg = 8; vl = 1;
        tick();
        st_start = 1'b0; st_valid = 1'b1; st_data = d0;
        tick();
        mdl[8][0] = d0;
        st_valid = 1'b0; st_start = 1'b1; st_reg = 9;
        #1;
        n_checks++;
        if (st_done !== 1'b1) $display("FAIL bb_done1: got %b required 1", st_done);
        else n_pass++;
        tick();
        n_checks++;
        if (st_busy !== 1'b0) $display("FAIL bb_no_start_in_done: busy=%b required 0", st_busy);
        else n_pass++;
        tick();
        st_start = 1'b0;
        n_checks++;
        if (st_ready !== 1'b1) $display("FAIL bb_start_in_idle: ready=%b required 1", st_ready);
        else n_pass++;
        st_valid = 1'b1; st_data = d1;
        tick();
        mdl[9][0] = d1;
        st_valid = 1'b0;
        n_checks++;
        if (st_done !== 1'b1) $display("FAIL bb_done2: got %b required 1", st_done);
        else n_pass++;
        tick();
        vl = 5; ra1 = 8; ra2 = 9;
        #1;
        n_checks++;
        if (st_busy !== 1'b0 || rd1 !== exp_rd(8, 5) || rd2 !== exp_rd(9, 5))
            $display("FAIL bb_data: busy=%b rd1=%h rd2=%h required 0 %h %h",
                     st_busy, rd1, rd2, exp_rd(8, 5), exp_rd(9, 5));
        else n_pass++;
    endtask

    task automatic test_edge_cases();
        int rs, re, ds, se;
        par_write(11, rand_vec(), 7);
        par_write(11, rand_vec(), 0);
        vl = 7; ra1 = 11;
        #1;
        n_checks++;
        if (rd1 !== exp_rd(11, 5))
            $display("FAIL vl_clamp: rd1=%h required %h", rd1, exp_rd(11, 5));
        else n_pass++;
        run_stream(6, 0, 0, 0, rs, re, ds, se);
        vl = 5; ra1 = 6;
        #1;
        n_checks++;
        if (rs !== 0 || ds !== 1 || se !== 0 || rd1 !== exp_rd(6, 5))
            $display("FAIL stream_vl0: ready=%0d done=%0d seq_err=%0d rd1=%h required 0 1 0 %h",
                     rs, ds, se, rd1, exp_rd(6, 5));
        else n_pass++;
        run_stream(12, 7, 0, 30, rs, re, ds, se);
        vl = 5; ra1 = 12;
        #1;
        n_checks++;
        if (rs !== re || ds !== 1 || se !== 0 || rd1 !== exp_rd(12, 5))
            $display("FAIL stream_vl7: ready=%0d/%0d done=%0d seq_err=%0d rd1=%h required %h",
                     rs, re, ds, se, rd1, exp_rd(12, 5));
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int rs, re, ds, se, dseen;
        st_start = 1'b1; st_reg = 10; vl = 5;
        tick();
        st_start = 1'b0; st_valid = 1'b1; st_data = $urandom;
        tick();
        st_data = $urandom;
        tick();
        st_valid = 1'b0;
        #2 reset = 1'b1;
        ra1 = 10;
        #1;
        n_checks++;
        if ({st_busy, st_ready, st_done} !== 3'b000 || rd1 !== '0)
            $display("FAIL midstream_reset: busy/ready/done=%b rd1=%h required 000 0",
                     {st_busy, st_ready, st_done}, rd1);
        else n_pass++;
        dseen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (st_done !== 1'b0) dseen++;
        end
        reset = 1'b0;
        mdl_clear();
        n_checks++;
        if (dseen !== 0) $display("FAIL midstream_no_done: done cycles=%0d required 0", dseen);
        else n_pass++;
        run_stream(10, 5, 0, 25, rs, re, ds, se);
        vl = 5; ra1 = 10;
        #1;
        n_checks++;
        if (rs !== re || ds !== 1 || se !== 0 || rd1 !== exp_rd(10, 5))
            $display("FAIL midstream_restart: ready=%0d/%0d done=%0d seq_err=%0d rd1=%h required %h",
                     rs, re, ds, se, rd1, exp_rd(10, 5));
        else n_pass++;
    endtask

    task automatic test_random_ops();
        int rs, re, ds, se, r;
        for (int k = 0; k < 6; k++) begin
            par_write($urandom_range(NREGS - 1), rand_vec(), $urandom_range(7));
            par_write($urandom_range(NREGS - 1), rand_vec(), $urandom_range(7));
            r = $urandom_range(NREGS - 1);
            run_stream(r, $urandom_range(1, 7), 0, $urandom_range(10, 60), rs, re, ds, se);
            n_checks++;
            if (rs !== re || ds !== 1 || se !== 0)
                $display("FAIL random_stream %0d: ready=%0d/%0d done=%0d seq_err=%0d", k, rs, re, ds, se);
            else n_pass++;
        end
        for (int q = 0; q < NREGS; q++) begin
            ra1 = RW'(q); ra2 = RW'(NREGS - 1 - q); vl = VLW'($urandom_range(7));
            #1;
            n_checks++;
            if (rd1 !== exp_rd(q, int'(vl)) || rd2 !== exp_rd(NREGS - 1 - q, int'(vl)))
                $display("FAIL random_sweep r%0d: rd1=%h rd2=%h required %h %h", q, rd1, rd2,
                         exp_rd(q, int'(vl)), exp_rd(NREGS - 1 - q, int'(vl)));
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; vl = '0; ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0;
        st_start = 1'b0; st_reg = '0; st_valid = 1'b0; st_data = '0;
        mdl_clear();
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_masked_write();
        test_stream_stalls();
        test_collision();
        test_back_to_back();
        test_edge_cases();
        test_reset_midstream();
        test_random_ops();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vregfile_stream.md
# vregfile_stream

Parametrised vector register file for the vector datapath: `NREGS` registers of `LANES` elements of `XLEN` bits each. It provides:
- two full-vector combinational read ports;
- one full-vector parallel write port, masked by the active vector length;
- a lane-serial streaming write port (start / valid / ready handshake) that fills one register one element per cycle, for memory-to-vector loads.

It sits between the decode/control unit and the vector ALU lanes.

## Interface
Parameters:
- `NREGS`, 16, number of vector registers; `RW = $clog2(NREGS)`
- `LANES`, 5, elements per register; `VLW = $clog2(LANES+1)`
- `XLEN`, 32, element width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `vl`  in  VLW  active vector length; `vl_eff = min(vl, LANES)`
- `ra1`, `ra2`  in  RW  read register addresses
- `rd1`, `rd2`  out  LANES*XLEN  read vectors; lane i occupies `[i*XLEN +: XLEN]`
- `we`  in  1  parallel write enable
- `wa`  in  RW  parallel write address
- `wd`  in  LANES*XLEN  parallel write data, same lane packing as `rd1`/`rd2`
- `st_start`  in  1  request a streaming fill
- `st_reg`  in  RW  streaming target register, sampled with `st_start`
- `st_valid`  in  1  streaming element valid
- `st_data`  in  XLEN  streaming element
- `st_ready`  out  1  streaming element accepted this cycle when high together with `st_valid`
- `st_busy`  out  1  a stream is in progress
- `st_done`  out  1  one-cycle pulse marking stream completion
- `wr_conflict`  out  1  one-cycle pulse: a parallel write was dropped

## Operation
Storage:
- `rf[NREGS][LANES]`, `XLEN` bits per element. All elements are 0 after reset.

Reads (combinational, no write forwarding):
- Lane i of `rd1` is `rf[ra1][i]` if `i < vl_eff`, else 0. `rd2` is the same using `ra2`.
- The mask uses the current `vl`, not the latched stream length.

Parallel write:
- On `clk` with `we=1`: `rf[wa][i] <= wd lane i` for every `i < vl_eff`. Lanes at or above `vl_eff` keep their value.
- `vl_eff = 0` writes nothing.

Stream FSM states: IDLE, STREAM, DONE.
- IDLE, `st_start=1`, `vl_eff>0`: latch `tgt<=st_reg`, `len<=vl_eff`, `cnt<=0`; go to STREAM.
- IDLE, `st_start=1`, `vl_eff=0`: go to DONE; no writes.
- STREAM: `st_ready=1`. Each cycle with `st_valid=1`: `rf[tgt][cnt] <= st_data`, `cnt++`. On the accept where `cnt == len-1`, go to DONE. If `st_valid=0`, the state holds.
- DONE: `st_done=1`, `st_ready=0`; go to IDLE next cycle.
- `st_start` outside IDLE is ignored.
- `st_busy = (state != IDLE)`. `st_ready` and `st_done` decode the state register only.

Collision rules:
- STREAM and `we=1` with `wa == tgt`: the entire parallel write is dropped. `wr_conflict` pulses high the following cycle. The stream write proceeds.
- STREAM and `we=1` with `wa != tgt`: both writes occur in the same cycle.
- In IDLE or DONE, parallel writes are never dropped.

Reset mid-stream:
- Aborts the stream: state returns to IDLE, `cnt` and `len` go to 0, all registers are cleared.
- No `st_done` pulse is produced.

## Timing
Reset values:
- `st_ready=0`, `st_busy=0`, `st_done=0`, `wr_conflict=0`.
- `rd1` and `rd2` read 0 in every lane.

Latency:
- Written data appears on `rd*` in the cycle after the write edge. A read of the same register in the write cycle returns the old data.
- Stream, no stalls: `st_start` at edge 0; `st_ready` high in cycles 1..len; DONE in cycle len+1; back in IDLE at cycle len+2.
- A new `st_start` is accepted in the IDLE cycle immediately after DONE. `st_start` is not accepted in the DONE cycle itself.
- `st_start` with `vl_eff=0`: DONE (`st_done=1`) in cycle 1, IDLE in cycle 2.
- `wr_conflict`: registered; asserted exactly one cycle after the dropped write; high for one cycle per dropped write.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> immediately `rd1`=`rd2`=0 for every `ra`, and `st_busy=0`, `st_ready=0`, `st_done=0`, `wr_conflict=0`.
- **Masked write/read:** `vl=3`, `we` to r1 with `wd` lanes {1,2,3,4,5} -> with `vl=5`, `rd1` of r1 reads {1,2,3,0,0}. Then `vl=2` -> reads {1,2,0,0,0}.
- **Stream with stalls:** `vl=5`, start on r2, feed 3,4,5,6,7 with `st_valid` low for 2 cycles after the 2nd element -> 7 cycles of `st_ready`, one `st_done` pulse, r2 reads {3,4,5,6,7}.
- **Collision:** during a stream to r2, `we` to r2 with all lanes 0xFF -> write dropped, `wr_conflict` high for exactly one cycle, r2 holds the streamed data. A simultaneous `we` to r3 lands normally.
- **Edge cases:** `st_start` with `vl=0` -> `st_done` in cycle 1, no writes. `st_start` during STREAM -> ignored. `vl=7` (above `LANES`) -> clamped to 5 lanes.
- **Reset mid-stream:** assert `reset` after 2 elements -> state returns to IDLE, target register reads all zero, no `st_done`. A new stream then completes normally.
